// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - five-slot round-robin arbiter onto a single qspi read/write bus
// Slots: 0 i_rd, 1 d_rd, 2 d_wr, 3 u_rd, 4 u_wr; one downstream transaction in flight at a time.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read_req,
  input  logic        i_read_w,
  input  logic        i_read_hw,
  input  logic [31:0] i_read_adr,
  input  logic        d_read_req,
  input  logic        d_read_w,
  input  logic        d_read_hw,
  input  logic [31:0] d_read_adr,
  input  logic        d_write_req,
  input  logic        d_write_w,
  input  logic        d_write_hw,
  input  logic [31:0] d_write_adr,
  input  logic [31:0] d_write_data,
  input  logic        u_read_req,
  input  logic        u_read_w,
  input  logic [31:0] u_read_adr,
  input  logic        u_write_req,
  input  logic        u_write_w,
  input  logic [31:0] u_write_adr,
  input  logic [31:0] u_write_data,
  output logic        read_req,
  output logic        read_w,
  output logic        read_hw,
  output logic [31:0] read_adr,
  output logic        write_req,
  output logic        write_w,
  output logic        write_hw,
  output logic [31:0] write_adr,
  output logic [31:0] write_data,
  input  logic        read_valid,
  input  logic        write_finish,
  output logic        i_read_valid,
  output logic        d_read_valid,
  output logic        u_read_valid,
  output logic        d_write_finish,
  output logic        u_write_finish,
  output logic        busy,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [4:0]  pend_q, pend_d;
  logic [4:0]  w_q, w_d, hw_q, hw_d;
  logic [31:0] adr_q [5];
  logic [31:0] adr_d [5];
  logic [31:0] d_wdata_q, d_wdata_d, u_wdata_q, u_wdata_d;
  logic [2:0]  last_q, last_d, grant_q, grant_d;
  logic [15:0] cnt_q, cnt_d;

  logic        rd_req_q, rd_req_d, rd_w_q, rd_w_d, rd_hw_q, rd_hw_d;
  logic [31:0] rd_adr_q, rd_adr_d;
  logic        wr_req_q, wr_req_d, wr_w_q, wr_w_d, wr_hw_q, wr_hw_d;
  logic [31:0] wr_adr_q, wr_adr_d, wr_data_q, wr_data_d;

  logic [4:0]  req_v, req_w, req_hw;
  logic [31:0] req_adr [5];
  logic        done, tmo, finish, found;
  logic [2:0]  sel, cand;
  logic [4:0]  cpl;

  assign req_v  = {u_write_req, u_read_req, d_write_req, d_read_req, i_read_req};
  assign req_w  = {u_write_w, u_read_w, d_write_w, d_read_w, i_read_w};
  assign req_hw = {1'b0, 1'b0, d_write_hw, d_read_hw, i_read_hw};
  assign req_adr[0] = i_read_adr;
  assign req_adr[1] = d_read_adr;
  assign req_adr[2] = d_write_adr;
  assign req_adr[3] = u_read_adr;
  assign req_adr[4] = u_write_adr;

  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  // Completion is combinational so the source pulse lines up with downstream read data.
  assign done   = ((state_q == RD_WAIT) && read_valid) || ((state_q == WR_WAIT) && write_finish);
  assign tmo    = (state_q != IDLE) && (cnt_q == TMO_LAST);
  assign finish = done || tmo;
  assign cpl    = (finish && !rst) ? (5'b00001 << grant_q) : 5'b00000;

  assign i_read_valid   = cpl[0];
  assign d_read_valid   = cpl[1];
  assign d_write_finish = cpl[2];
  assign u_read_valid   = cpl[3];
  assign u_write_finish = cpl[4];
  assign bus_timeout    = tmo && !rst;
  assign busy           = !rst && ((state_q != IDLE) || (|pend_q));

  assign read_req   = rd_req_q;
  assign read_w     = rd_w_q;
  assign read_hw    = rd_hw_q;
  assign read_adr   = rd_adr_q;
  assign write_req  = wr_req_q;
  assign write_w    = wr_w_q;
  assign write_hw   = wr_hw_q;
  assign write_adr  = wr_adr_q;
  assign write_data = wr_data_q;

  always_comb begin
    found = 1'b0;
    sel   = 3'd0;
    cand  = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      cand = wrap5(4'(last_q) + 4'(k));
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    w_d       = w_q;
    hw_d      = hw_q;
    adr_d     = adr_q;
    d_wdata_d = d_wdata_q;
    u_wdata_d = u_wdata_q;
    last_d    = last_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    rd_req_d  = 1'b0;
    rd_w_d    = rd_w_q;
    rd_hw_d   = rd_hw_q;
    rd_adr_d  = rd_adr_q;
    wr_req_d  = 1'b0;
    wr_w_d    = wr_w_q;
    wr_hw_d   = wr_hw_q;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = sel;
          last_d  = sel;
          cnt_d   = 16'd0;
          if (sel == 3'd2 || sel == 3'd4) begin
            state_d   = WR_WAIT;
            wr_req_d  = 1'b1;
            wr_w_d    = w_q[sel];
            wr_hw_d   = hw_q[sel];
            wr_adr_d  = adr_q[sel];
            wr_data_d = (sel == 3'd2) ? d_wdata_q : u_wdata_q;
          end else begin
            state_d  = RD_WAIT;
            rd_req_d = 1'b1;
            rd_w_d   = w_q[sel];
            rd_hw_d  = hw_q[sel];
            rd_adr_d = adr_q[sel];
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (finish) begin
          pend_d[grant_q] = 1'b0;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept after the clear above so a re-request in the completion cycle wins.
    for (int i = 0; i < 5; i++) begin
      if (req_v[i] && !pend_d[i]) begin
        pend_d[i] = 1'b1;
        w_d[i]    = req_w[i];
        hw_d[i]   = req_hw[i];
        adr_d[i]  = req_adr[i];
      end
    end
    if (d_write_req && !pend_q[2]) d_wdata_d = d_write_data;
    if (d_write_req && finish && grant_q == 3'd2) d_wdata_d = d_write_data;
    if (u_write_req && !pend_q[4]) u_wdata_d = u_write_data;
    if (u_write_req && finish && grant_q == 3'd4) u_wdata_d = u_write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      w_q       <= '0;
      hw_q      <= '0;
      for (int i = 0; i < 5; i++) adr_q[i] <= '0;
      d_wdata_q <= '0;
      u_wdata_q <= '0;
      last_q    <= 3'd4;
      grant_q   <= '0;
      cnt_q     <= '0;
      rd_req_q  <= 1'b0;
      rd_w_q    <= 1'b0;
      rd_hw_q   <= 1'b0;
      rd_adr_q  <= '0;
      wr_req_q  <= 1'b0;
      wr_w_q    <= 1'b0;
      wr_hw_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      w_q       <= w_d;
      hw_q      <= hw_d;
      adr_q     <= adr_d;
      d_wdata_q <= d_wdata_d;
      u_wdata_q <= u_wdata_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      rd_req_q  <= rd_req_d;
      rd_w_q    <= rd_w_d;
      rd_hw_q   <= rd_hw_d;
      rd_adr_q  <= rd_adr_d;
      wr_req_q  <= wr_req_d;
      wr_w_q    <= wr_w_d;
      wr_hw_q   <= wr_hw_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule
